// File: rtl/seq_divider_16x8.sv
// Sequential restoring divider: 16-bit unsigned dividend / 8-bit unsigned divisor,
// one quotient bit per clock MSB first, with a start/busy/done handshake.
module seq_divider_16x8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_zero
);

    localparam int unsigned DVD_W = 16;
    localparam int unsigned DVS_W = 8;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ZERO = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [DVS_W-1:0]   dvs_q,       dvs_d;
    logic [DVD_W-1:0]   q_q,         q_d;
    logic [DVS_W-1:0]   rem_q,       rem_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic [DVD_W-1:0]   quotient_q,  quotient_d;
    logic [DVS_W-1:0]   remainder_q, remainder_d;
    logic               div_zero_q,  div_zero_d;

    // Restoring step: shift next dividend bit into the partial remainder, then trial-subtract at 9 bits
    logic [DVS_W:0]     trial_c;
    logic               fits_c;

    always_comb begin
        trial_c = {rem_q, q_q[DVD_W-1]};
        fits_c  = (trial_c >= {1'b0, dvs_q});
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dvs_d       = dvs_q;
        q_d         = q_q;
        rem_d       = rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvs_d   = divisor;
                    q_d     = dividend;
                    rem_d   = '0;
                    count_d = '0;
                    if (divisor == '0) begin
                        state_d = ST_ZERO;
                    end else begin
                        state_d = ST_BUSY;
                        busy_d  = 1'b1;
                    end
                end
            end

            ST_BUSY: begin
                rem_d   = fits_c ? DVS_W'(trial_c - {1'b0, dvs_q}) : trial_c[DVS_W-1:0];
                q_d     = {q_q[DVD_W-2:0], fits_c};
                count_d = CNT_W'(count_q + CNT_W'(1));
                if (count_q == LAST_ITER) begin
                    state_d     = ST_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = q_d;
                    remainder_d = rem_d;
                    div_zero_d  = 1'b0;
                end
            end

            // Divide by zero skips iteration; the captured dividend low byte becomes the remainder
            ST_ZERO: begin
                state_d     = ST_DONE;
                done_d      = 1'b1;
                quotient_d  = '1;
                remainder_d = q_q[DVS_W-1:0];
                div_zero_d  = 1'b1;
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            dvs_q       <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dvs_q       <= dvs_d;
            q_q         <= q_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider_16x8.sv
// Self-checking bench for seq_divider_16x8: directed cases plus randomized
// back-to-back operations checked against plain-arithmetic division.
module tb_seq_divider_16x8;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    int checks;
    int errors;

    logic [15:0] prev_q;
    logic [7:0]  prev_r;
    logic        prev_dz;

    seq_divider_16x8 dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs held from the previous result while nothing new is reported
    task automatic chk_held(input string tag);
        chk({tag, "_q"},  32'(quotient),  32'(prev_q));
        chk({tag, "_r"},  32'(remainder), 32'(prev_r));
        chk({tag, "_dz"}, 32'(div_zero),  32'(prev_dz));
    endtask

    // Issue one operation at a negedge in IDLE; returns at the negedge when the DUT is IDLE again.
    // disturb_cyc > 0 pulses start with other operands at that busy cycle (must be ignored).
    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int disturb_cyc);
        logic [15:0] exp_q;
        logic [7:0]  exp_r;
        logic [15:0] r16;
        if (b == 8'd0) begin
            exp_q = 16'hFFFF;
            exp_r = a[7:0];
        end else begin
            exp_q = a / 16'(b);
            r16   = a % 16'(b);
            exp_r = r16[7:0];
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        if (b != 8'd0) begin
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                chk("busy_run", 32'(busy), 32'd1);
                chk("done_run", 32'(done), 32'd0);
                chk_held("hold_run");
                if (disturb_cyc != 0 && i == disturb_cyc) begin
                    start    = 1'b1;
                    dividend = 16'd5;
                    divisor  = 8'd5;
                end else if (disturb_cyc != 0 && i == disturb_cyc + 1) begin
                    start    = 1'b0;
                    dividend = 16'($urandom);
                    divisor  = 8'($urandom);
                end
            end
        end else begin
            @(negedge clk);
            chk("busy_dz0", 32'(busy), 32'd0);
            chk("done_dz0", 32'(done), 32'd0);
            chk_held("hold_dz0");
        end
        @(negedge clk);
        chk("busy_res", 32'(busy), 32'd0);
        chk("done_res", 32'(done), 32'd1);
        chk("quotient", 32'(quotient), 32'(exp_q));
        chk("remainder", 32'(remainder), 32'(exp_r));
        chk("div_zero", 32'(div_zero), 32'(b == 8'd0));
        prev_q  = exp_q;
        prev_r  = exp_r;
        prev_dz = (b == 8'd0);
        @(negedge clk);
        chk("busy_post", 32'(busy), 32'd0);
        chk("done_post", 32'(done), 32'd0);
        chk_held("hold_post");
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        checks   = 0;
        errors   = 0;
        prev_q   = '0;
        prev_r   = '0;
        prev_dz  = 1'b0;
        reset    = 1'b1;
        start    = 1'b1;
        dividend = 16'd100;
        divisor  = 8'd7;

        // Reset wins over a simultaneous start
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_held("rst");
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        do_op(16'd100, 8'd7, 0);
        chk("t1_q", 32'(quotient), 32'd14);
        chk("t1_r", 32'(remainder), 32'd2);

        do_op(16'hFFFF, 8'd1, 0);
        chk("t2a_q", 32'(quotient), 32'hFFFF);
        do_op(16'hFFFF, 8'hFF, 0);
        chk("t2b_q", 32'(quotient), 32'h0101);
        chk("t2b_r", 32'(remainder), 32'h0);

        do_op(16'h1234, 8'd0, 0);
        chk("t3_r", 32'(remainder), 32'h34);
        chk("t3_dz", 32'(div_zero), 32'd1);

        do_op(16'd1000, 8'd10, 5);
        chk("t4_q", 32'(quotient), 32'd100);
        chk("t4_r", 32'(remainder), 32'd0);

        // Reset mid-operation aborts without a done pulse
        start    = 1'b1;
        dividend = 16'd500;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            chk("t5_busy", 32'(busy), 32'd1);
        end
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        prev_q  = '0;
        prev_r  = '0;
        prev_dz = 1'b0;
        chk("t5_busy_rst", 32'(busy), 32'd0);
        chk("t5_done_rst", 32'(done), 32'd0);
        chk_held("t5_rst");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_nodone", 32'(done), 32'd0);
            chk("t5_nobusy", 32'(busy), 32'd0);
        end
        do_op(16'd7, 8'd8, 0);
        chk("t5_q", 32'(quotient), 32'd0);
        chk("t5_r", 32'(remainder), 32'd7);

        // Randomized back-to-back operations, with occasional zero and extreme divisors
        for (int n = 0; n < 2000; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 15))
                0:       rb = 8'd0;
                1:       rb = 8'd1;
                2:       rb = 8'hFF;
                default: rb = 8'($urandom);
            endcase
            do_op(ra, rb, (n % 7 == 0) ? int'($urandom_range(1, 14)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
